// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipeline_hazard_ctrl                                         |
// | Description : Hazard controller for a 5-stage in-order pipeline.           |
// |               Tracks in-flight writers in a 3-slot scoreboard (EX/MEM/WB), |
// |               inserts one bubble on load-use, flushes on redirect, selects |
// |               per-operand forwarding sources and counts bubble cycles.     |
// | Ports       : clk, rst            - clock / synchronous active-high reset  |
// |               dec_*               - decode-stage instruction fields        |
// |               redirect            - taken branch/jump resolved in EX       |
// |               f_to_d_enable/flush - fetch->decode flop control             |
// |               d_to_e_enable/bubble- decode->execute flop control           |
// |               fwd_sel_a/b         - operand source select                  |
// |               bubble_count        - saturating bubble-cycle counter        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pipeline_hazard_ctrl #(
   parameter int REGISTER_SIZE = 5,
   parameter int CNT_SIZE      = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     dec_valid,
   input  logic [REGISTER_SIZE-1:0] dec_rs1,
   input  logic [REGISTER_SIZE-1:0] dec_rs2,
   input  logic                     dec_rs1_used,
   input  logic                     dec_rs2_used,
   input  logic [REGISTER_SIZE-1:0] dec_rd,
   input  logic                     dec_rd_we,
   input  logic                     dec_is_load,
   input  logic                     redirect,
   output logic                     f_to_d_enable,
   output logic                     d_to_e_enable,
   output logic                     d_to_e_bubble,
   output logic                     f_to_d_flush,
   output logic [1:0]               fwd_sel_a,
   output logic [1:0]               fwd_sel_b,
   output logic [CNT_SIZE-1:0]      bubble_count
);

   localparam logic [1:0]          c_fwd_rf      = 2'd0;
   localparam logic [1:0]          c_fwd_mem_dm  = 2'd1;
   localparam logic [1:0]          c_fwd_ex_alu  = 2'd2;
   localparam logic [1:0]          c_fwd_mem_alu = 2'd3;
   localparam logic [CNT_SIZE-1:0] c_cnt_max     = {CNT_SIZE{1'b1}};

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   state_t                     r_state;

   logic                       r_ex_valid, r_mem_valid, r_wb_valid;
   logic [REGISTER_SIZE-1:0]   r_ex_rd, r_mem_rd, r_wb_rd;
   logic                       r_ex_load, r_mem_load, r_wb_load;
   logic [CNT_SIZE-1:0]        r_bubble_count;

   logic w_ex_m1, w_ex_m2, w_mem_m1, w_mem_m2, w_wb_m1, w_wb_m2;
   logic w_load_use, w_flush, w_stall, w_issue;
   // WB is_load is carried for slot uniformity but no decision depends on it.
   logic w_unused_wb_load;

   function automatic logic slot_match(input logic                     v,
                                       input logic [REGISTER_SIZE-1:0] rd,
                                       input logic [REGISTER_SIZE-1:0] rs,
                                       input logic                     used);
      return v && (rd == rs) && (rs != '0) && used;
   endfunction

   // Youngest matching producer wins.
   function automatic logic [1:0] fwd_pick(input logic ex_m, input logic ex_ld,
                                           input logic mem_m, input logic mem_ld,
                                           input logic wb_m);
      if (ex_m && !ex_ld)
         return c_fwd_ex_alu;
      else if (ex_m)
         return c_fwd_rf;    // load still in EX: decode is stalled this cycle
      else if (mem_m)
         return mem_ld ? c_fwd_mem_dm : c_fwd_mem_alu;
      else if (wb_m)
         return c_fwd_rf;    // register file writes through to the read port
      else
         return c_fwd_rf;
   endfunction

   assign w_ex_m1  = slot_match(r_ex_valid,  r_ex_rd,  dec_rs1, dec_rs1_used);
   assign w_ex_m2  = slot_match(r_ex_valid,  r_ex_rd,  dec_rs2, dec_rs2_used);
   assign w_mem_m1 = slot_match(r_mem_valid, r_mem_rd, dec_rs1, dec_rs1_used);
   assign w_mem_m2 = slot_match(r_mem_valid, r_mem_rd, dec_rs2, dec_rs2_used);
   assign w_wb_m1  = slot_match(r_wb_valid,  r_wb_rd,  dec_rs1, dec_rs1_used);
   assign w_wb_m2  = slot_match(r_wb_valid,  r_wb_rd,  dec_rs2, dec_rs2_used);
   assign w_unused_wb_load = r_wb_load;

   assign w_load_use = dec_valid && r_ex_load && (w_ex_m1 || w_ex_m2);

   // Redirect overrides everything; a stall is only raised from RUN since the
   // cycle after a stall always has an empty EX slot.
   assign w_flush = redirect || (r_state == ST_FLUSH);
   assign w_stall = (r_state == ST_RUN) && w_load_use && !redirect;
   assign w_issue = d_to_e_enable && !d_to_e_bubble;

   assign f_to_d_flush  = w_flush;
   assign d_to_e_bubble = w_flush || w_stall;
   assign f_to_d_enable = !w_stall;
   assign d_to_e_enable = 1'b1;
   assign fwd_sel_a     = fwd_pick(w_ex_m1, r_ex_load, w_mem_m1, r_mem_load, w_wb_m1);
   assign fwd_sel_b     = fwd_pick(w_ex_m2, r_ex_load, w_mem_m2, r_mem_load, w_wb_m2);
   assign bubble_count  = r_bubble_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= ST_RUN;
         r_ex_valid     <= 1'b0;
         r_ex_rd        <= '0;
         r_ex_load      <= 1'b0;
         r_mem_valid    <= 1'b0;
         r_mem_rd       <= '0;
         r_mem_load     <= 1'b0;
         r_wb_valid     <= 1'b0;
         r_wb_rd        <= '0;
         r_wb_load      <= 1'b0;
         r_bubble_count <= '0;
      end else begin
         if (redirect)
            r_state <= ST_FLUSH;
         else if (w_stall)
            r_state <= ST_STALL;
         else
            r_state <= ST_RUN;

         r_ex_valid  <= w_issue && dec_valid && dec_rd_we && (dec_rd != '0);
         r_ex_rd     <= dec_rd;
         r_ex_load   <= w_issue && dec_is_load;
         r_mem_valid <= r_ex_valid;
         r_mem_rd    <= r_ex_rd;
         r_mem_load  <= r_ex_load;
         r_wb_valid  <= r_mem_valid;
         r_wb_rd     <= r_mem_rd;
         r_wb_load   <= r_mem_load;

         if (d_to_e_bubble && (r_bubble_count != c_cnt_max))
            r_bubble_count <= r_bubble_count + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pipeline_hazard_ctrl                                      |
// | Description : Randomized scoreboard bench for pipeline_hazard_ctrl. The    |
// |               driver applies inputs each cycle and queues the reference    |
// |               model's expected response; a monitor pops and compares.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pipeline_hazard_ctrl;

   localparam int RS      = 5;
   localparam int CS      = 16;
   localparam int CNT_MAX = (1 << CS) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          dec_valid;
   logic [RS-1:0] dec_rs1, dec_rs2, dec_rd;
   logic          dec_rs1_used, dec_rs2_used, dec_rd_we, dec_is_load;
   logic          redirect;
   logic          f_to_d_enable, d_to_e_enable, d_to_e_bubble, f_to_d_flush;
   logic [1:0]    fwd_sel_a, fwd_sel_b;
   logic [CS-1:0] bubble_count;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.REGISTER_SIZE(RS), .CNT_SIZE(CS)) dut (
      .clk          (clk),
      .rst          (rst),
      .dec_valid    (dec_valid),
      .dec_rs1      (dec_rs1),
      .dec_rs2      (dec_rs2),
      .dec_rs1_used (dec_rs1_used),
      .dec_rs2_used (dec_rs2_used),
      .dec_rd       (dec_rd),
      .dec_rd_we    (dec_rd_we),
      .dec_is_load  (dec_is_load),
      .redirect     (redirect),
      .f_to_d_enable(f_to_d_enable),
      .d_to_e_enable(d_to_e_enable),
      .d_to_e_bubble(d_to_e_bubble),
      .f_to_d_flush (f_to_d_flush),
      .fwd_sel_a    (fwd_sel_a),
      .fwd_sel_b    (fwd_sel_b),
      .bubble_count (bubble_count)
   );

   // A producer still in flight: the instruction issued one cycle ago is in
   // EX, two cycles ago in MEM. Older ones are already visible in the RF.
   typedef struct {
      bit       v;
      int       rd;
      bit       ld;
   } producer_t;

   typedef struct {
      int  cyc;
      bit  chk;
      bit  fen, den, bub, fl;
      bit  care_a, care_b;
      int  fa, fb;
      int  cnt;
   } exp_t;

   exp_t      q[$];
   int        checks = 0;
   int        errors = 0;
   int        cyc    = 0;

   producer_t in_ex, in_mem;
   bit        flushing_next;   // a redirect happened last cycle
   bit        just_stalled;    // last cycle was a load-use bubble
   int        m_cnt;

   function automatic bit reads(producer_t p, int rs, bit used);
      return p.v && used && rs != 0 && p.rd == rs;
   endfunction

   // Expected operand source; care=0 where the operand waits on a load in EX.
   task automatic expect_fwd(input int rs, input bit used, output bit care, output int sel);
      care = 1'b1;
      sel  = 0;
      if (reads(in_ex, rs, used)) begin
         if (in_ex.ld) care = 1'b0;
         else          sel  = 2;
      end else if (reads(in_mem, rs, used)) begin
         sel = in_mem.ld ? 1 : 3;
      end
   endtask

   task automatic model_cycle();
      exp_t e;
      bit   hz;
      e.cyc = cyc;
      e.chk = !rst;
      hz = dec_valid && in_ex.ld &&
           (reads(in_ex, int'(dec_rs1), dec_rs1_used) || reads(in_ex, int'(dec_rs2), dec_rs2_used));
      e.den = 1'b1;
      if (redirect || flushing_next) begin
         e.fl = 1'b1; e.bub = 1'b1; e.fen = 1'b1;
      end else if (hz && !just_stalled) begin
         e.fl = 1'b0; e.bub = 1'b1; e.fen = 1'b0;
      end else begin
         e.fl = 1'b0; e.bub = 1'b0; e.fen = 1'b1;
      end
      expect_fwd(int'(dec_rs1), dec_rs1_used, e.care_a, e.fa);
      expect_fwd(int'(dec_rs2), dec_rs2_used, e.care_b, e.fb);
      e.cnt = m_cnt;
      q.push_back(e);

      if (rst) begin
         in_ex = '{0, 0, 0}; in_mem = '{0, 0, 0};
         flushing_next = 0; just_stalled = 0; m_cnt = 0;
      end else begin
         if (e.bub && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
         in_mem = in_ex;
         in_ex.v  = !e.bub && dec_valid && dec_rd_we && dec_rd != 0;
         in_ex.rd = int'(dec_rd);
         in_ex.ld = !e.bub && dec_is_load;
         flushing_next = redirect;
         just_stalled  = e.bub && !e.fl;
      end
   endtask

   task automatic check(input string name, input int cy, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", name, cy, got, want);
      end
   endtask

   // Monitor: outputs are settled half a cycle after inputs change.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            if (e.chk) begin
               check("f_to_d_enable", e.cyc, int'(f_to_d_enable), int'(e.fen));
               check("d_to_e_enable", e.cyc, int'(d_to_e_enable), int'(e.den));
               check("d_to_e_bubble", e.cyc, int'(d_to_e_bubble), int'(e.bub));
               check("f_to_d_flush",  e.cyc, int'(f_to_d_flush),  int'(e.fl));
               if (e.care_a) check("fwd_sel_a", e.cyc, int'(fwd_sel_a), e.fa);
               if (e.care_b) check("fwd_sel_b", e.cyc, int'(fwd_sel_b), e.fb);
               check("bubble_count", e.cyc, int'(bubble_count), e.cnt);
            end
         end
      end
   end

   task automatic drive(input bit r, input bit force_redirect);
      rst          = r;
      dec_valid    = ($urandom_range(0, 9) != 0);
      dec_rs1      = RS'($urandom_range(0, 3));
      dec_rs2      = RS'($urandom_range(0, 3));
      dec_rs1_used = ($urandom_range(0, 4) != 0);
      dec_rs2_used = ($urandom_range(0, 4) != 0);
      dec_rd       = RS'($urandom_range(0, 3));
      dec_rd_we    = ($urandom_range(0, 4) != 0);
      dec_is_load  = ($urandom_range(0, 4) < 2);
      redirect     = force_redirect || ($urandom_range(0, 11) == 0);
   endtask

   task automatic idle(input bit r);
      rst = r; dec_valid = 0; dec_rs1 = '0; dec_rs2 = '0; dec_rs1_used = 0;
      dec_rs2_used = 0; dec_rd = '0; dec_rd_we = 0; dec_is_load = 0; redirect = 0;
   endtask

   task automatic step_idle(input bit r);
      @(posedge clk); #1; cyc++;
      idle(r);
      model_cycle();
   endtask

   task automatic step_rand(input bit r, input bit force_redirect);
      @(posedge clk); #1; cyc++;
      drive(r, force_redirect);
      model_cycle();
   endtask

   initial begin
      in_ex = '{0, 0, 0}; in_mem = '{0, 0, 0};
      flushing_next = 0; just_stalled = 0; m_cnt = 0;
      idle(1'b1);

      // Reset, then idle cycles show the post-reset output values.
      for (int i = 0; i < 3; i++) step_idle(1'b1);
      for (int i = 0; i < 2; i++) step_idle(1'b0);

      // Random traffic with occasional mid-stream resets.
      for (int i = 0; i < 4000; i++)
         step_rand($urandom_range(0, 99) == 0, 1'b0);

      // Fresh reset, then sustained redirects drive the counter to saturation.
      step_idle(1'b1);
      for (int i = 0; i < CNT_MAX + 4; i++) step_rand(1'b0, 1'b1);
      for (int i = 0; i < 20; i++)           step_rand(1'b0, 1'b0);
      for (int i = 0; i < 3; i++)            step_rand(1'b0, 1'b1);

      @(posedge clk); #1;
      idle(1'b0);
      repeat (2) @(negedge clk);
      #1;
      check("queue_drained", cyc, q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
